// File: rtl/axi_wr_arb.sv
// axi_wr_arb: two-requester AXI4 write-channel arbiter.
// Whole bursts are granted round-robin. The grant is held from the AW issue
// through the WLAST beat. B responses are routed back in issue order using a
// small grant-order FIFO. All AW/W/B payload fields are pure muxes.
module axi_wr_arb #(
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_ID_WIDTH    = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // requester 0
    input  logic [AXI_ID_WIDTH-1:0]   s0_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [7:0]                s0_awlen,
    input  logic [2:0]                s0_awsize,
    input  logic [1:0]                s0_awburst,
    input  logic                      s0_awlock,
    input  logic [3:0]                s0_awcache,
    input  logic [2:0]                s0_awprot,
    input  logic                      s0_awvalid,
    output logic                      s0_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s0_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s0_wstrb,
    input  logic                      s0_wlast,
    input  logic                      s0_wvalid,
    output logic                      s0_wready,
    output logic [AXI_ID_WIDTH-1:0]   s0_bid,
    output logic [1:0]                s0_bresp,
    output logic                      s0_bvalid,
    input  logic                      s0_bready,
    // requester 1
    input  logic [AXI_ID_WIDTH-1:0]   s1_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [7:0]                s1_awlen,
    input  logic [2:0]                s1_awsize,
    input  logic [1:0]                s1_awburst,
    input  logic                      s1_awlock,
    input  logic [3:0]                s1_awcache,
    input  logic [2:0]                s1_awprot,
    input  logic                      s1_awvalid,
    output logic                      s1_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s1_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s1_wstrb,
    input  logic                      s1_wlast,
    input  logic                      s1_wvalid,
    output logic                      s1_wready,
    output logic [AXI_ID_WIDTH-1:0]   s1_bid,
    output logic [1:0]                s1_bresp,
    output logic                      s1_bvalid,
    input  logic                      s1_bready,
    // shared master port
    output logic [AXI_ID_WIDTH-1:0]   m_awid,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awlock,
    output logic [3:0]                m_awcache,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DATA_WIDTH-1:0] m_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [AXI_ID_WIDTH-1:0]   m_bid,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    // status
    output logic                      busy,
    output logic                      b_orphan
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             grant_reg, grant_next;
    logic             rr_last_reg, rr_last_next;

    // grant-order FIFO: one bit per outstanding burst naming its requester
    logic             order_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [1:0] awvalid_vec, wvalid_vec, wlast_vec, bready_vec;
    logic [1:0] awready_vec, wready_vec, bvalid_vec;
    logic       fifo_empty, fifo_full, head_bit;
    logic       aw_hs, w_last_hs, b_pop;

    assign awvalid_vec = {s1_awvalid, s0_awvalid};
    assign wvalid_vec  = {s1_wvalid,  s0_wvalid};
    assign wlast_vec   = {s1_wlast,   s0_wlast};
    assign bready_vec  = {s1_bready,  s0_bready};

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign head_bit   = order_mem[rd_ptr_reg];

    // Payload muxes follow the registered grant, even while not valid.
    assign m_awid    = grant_reg ? s1_awid    : s0_awid;
    assign m_awaddr  = grant_reg ? s1_awaddr  : s0_awaddr;
    assign m_awlen   = grant_reg ? s1_awlen   : s0_awlen;
    assign m_awsize  = grant_reg ? s1_awsize  : s0_awsize;
    assign m_awburst = grant_reg ? s1_awburst : s0_awburst;
    assign m_awlock  = grant_reg ? s1_awlock  : s0_awlock;
    assign m_awcache = grant_reg ? s1_awcache : s0_awcache;
    assign m_awprot  = grant_reg ? s1_awprot  : s0_awprot;
    assign m_wdata   = grant_reg ? s1_wdata   : s0_wdata;
    assign m_wstrb   = grant_reg ? s1_wstrb   : s0_wstrb;
    assign m_wlast   = grant_reg ? s1_wlast   : s0_wlast;

    assign aw_hs     = (state_reg == ST_ADDR) && awvalid_vec[grant_reg] && m_awready;
    assign w_last_hs = (state_reg == ST_DATA) && wvalid_vec[grant_reg] && m_wready
                       && wlast_vec[grant_reg];

    // The B path is independent of the FSM and only looks at the FIFO head.
    assign m_bready = !fifo_empty && bready_vec[head_bit];
    assign b_pop    = m_bvalid && m_bready;
    assign b_orphan = fifo_empty && m_bvalid;
    assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic is_grant;
            logic is_head;
            assign is_grant        = (gi == 1) ? grant_reg : ~grant_reg;
            assign is_head         = (gi == 1) ? head_bit  : ~head_bit;
            assign awready_vec[gi] = (state_reg == ST_ADDR) && is_grant && m_awready;
            assign wready_vec[gi]  = (state_reg == ST_DATA) && is_grant && m_wready;
            assign bvalid_vec[gi]  = !fifo_empty && is_head && m_bvalid;
        end
    endgenerate

    assign s0_awready = awready_vec[0];
    assign s1_awready = awready_vec[1];
    assign s0_wready  = wready_vec[0];
    assign s1_wready  = wready_vec[1];
    assign s0_bvalid  = bvalid_vec[0];
    assign s1_bvalid  = bvalid_vec[1];
    assign s0_bid     = m_bid;
    assign s1_bid     = m_bid;
    assign s0_bresp   = m_bresp;
    assign s1_bresp   = m_bresp;

    // Next-state logic: round-robin pick in IDLE, hold the grant through AW and W.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        rr_last_next = rr_last_reg;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_full && (|awvalid_vec)) begin
                    // On a tie the requester that did not go last wins.
                    grant_next = (&awvalid_vec) ? ~rr_last_reg : awvalid_vec[1];
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_awvalid = awvalid_vec[grant_reg];
                if (aw_hs) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_wvalid = wvalid_vec[grant_reg];
                if (w_last_hs) begin
                    rr_last_next = grant_reg;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM and arbitration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            rr_last_reg <= rr_last_next;
        end
    end

    // Grant-order FIFO pointers and occupancy; push on AW issue, pop on B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (aw_hs) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (b_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({aw_hs, b_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; contents are meaningful only below the occupancy count.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            order_mem[wr_ptr_reg] <= grant_reg;
        end
    end

endmodule
